// File: rtl/logic_proc_ctrl_if.sv
// Handshake bundle between the switch/button front end and the logic processor control FSM.
// master drives the user requests; slave (the controller) drives the register strobes.
interface logic_proc_ctrl_if;
    logic Execute;
    logic LoadA;
    logic LoadB;
    logic Ld_A;
    logic Ld_B;
    logic Sel_Comp;
    logic Shift_En;
    logic Busy;
    logic Done;

    modport master (
        output Execute, LoadA, LoadB,
        input  Ld_A, Ld_B, Sel_Comp, Shift_En, Busy, Done
    );

    modport slave (
        input  Execute, LoadA, LoadB,
        output Ld_A, Ld_B, Sel_Comp, Shift_En, Busy, Done
    );
endinterface

// File: rtl/logic_proc_ctrl.sv
// Control FSM sequencing the A/B shift-register unit: one compute/load cycle, WIDTH shifts, hold.
// Optional macro LP_EXEC_SYNC_EN adds a 2-flop synchronizer on Execute (+2 cycles latency).
module logic_proc_ctrl #(
    parameter int WIDTH = 8
) (
    input logic              Clk,
    input logic              Reset,
    logic_proc_ctrl_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        SHIFT   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             exec;

`ifdef LP_EXEC_SYNC_EN
    logic exec_meta;
    logic exec_sync;

    // Execute comes from an asynchronous button; both stages clear on reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            exec_meta <= 1'b0;
            exec_sync <= 1'b0;
        end else begin
            exec_meta <= bus.Execute;
            exec_sync <= exec_meta;
        end
    end

    assign exec = exec_sync;
`else
    assign exec = bus.Execute;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bus.Ld_A     = 1'b0;
        bus.Ld_B     = 1'b0;
        bus.Sel_Comp = 1'b0;
        bus.Shift_En = 1'b0;
        bus.Busy     = 1'b0;
        bus.Done     = 1'b0;

        case (state)
            IDLE: begin
                // User loads pass straight through only while idle, even alongside Execute.
                bus.Ld_A = bus.LoadA;
                bus.Ld_B = bus.LoadB;
                cnt_next = '0;
                if (exec) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                bus.Ld_A     = 1'b1;
                bus.Ld_B     = 1'b1;
                bus.Sel_Comp = 1'b1;
                bus.Busy     = 1'b1;
                cnt_next     = '0;
                state_next   = SHIFT;
            end
            SHIFT: begin
                bus.Shift_En = 1'b1;
                bus.Busy     = 1'b1;
                if (cnt == LAST) begin
                    cnt_next   = '0;
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HOLD: begin
                // Waiting for release guarantees one operation per button press.
                bus.Done = 1'b1;
                if (!exec) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_logic_proc_ctrl.sv
// Self-checking bench for logic_proc_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based model of the per-cycle output sequence.
module tb_logic_proc_ctrl;
    localparam int WIDTH = 8;
`ifdef LP_EXEC_SYNC_EN
    localparam int EXTRA_LAT = 2;
`else
    localparam int EXTRA_LAT = 0;
`endif

    logic Clk;
    logic Reset;
    logic_proc_ctrl_if bus ();

    logic_proc_ctrl #(.WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int testsRun    = 0;
    int testsFailed = 0;
    int shiftSeen   = 0;
    int cycleCount  = 0;
    int firstSelCycle;

    // Model: an accepted press queues its cycle-by-cycle outputs (0 = compute, 1 = shift).
    bit opQueue[$];
    bit mDone;
    bit pipe1;
    bit pipe2;

    task automatic checkOutput(input string tag, input logic la, input logic lb);
        logic [5:0] expected;
        logic [5:0] observed;
        observed = {bus.Ld_A, bus.Ld_B, bus.Sel_Comp, bus.Shift_En, bus.Busy, bus.Done};
        if (opQueue.size() > 0)
            expected = opQueue[0] ? 6'b000110 : 6'b111010;
        else if (mDone)
            expected = 6'b000001;
        else
            expected = {la, lb, 4'b0000};
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s cycle %0d: outputs observed=%b expected=%b", tag, cycleCount, observed, expected);
        end
        testsRun++;
        assert ((bus.Shift_En & (bus.Ld_A | bus.Ld_B)) === 1'b0) else begin
            testsFailed++;
            $error("[TB] FAIL %s_overlap cycle %0d: observed=%b expected=0", tag, cycleCount,
                   bus.Shift_En & (bus.Ld_A | bus.Ld_B));
        end
        if (bus.Shift_En === 1'b1) shiftSeen++;
        if (bus.Sel_Comp === 1'b1 && firstSelCycle < 0) firstSelCycle = cycleCount;
    endtask

    task automatic applyStimulus(input string tag, input logic e, input logic la, input logic lb, input logic r);
        bit execF;
        bus.Execute = e;
        bus.LoadA   = la;
        bus.LoadB   = lb;
        Reset       = r;
        #2;
        checkOutput(tag, la, lb);
        @(posedge Clk);
`ifdef LP_EXEC_SYNC_EN
        execF = pipe2;
        if (r) begin
            pipe1 = 1'b0;
            pipe2 = 1'b0;
        end else begin
            pipe2 = pipe1;
            pipe1 = e;
        end
`else
        execF = e;
`endif
        if (r) begin
            opQueue.delete();
            mDone = 1'b0;
        end else if (opQueue.size() > 0) begin
            void'(opQueue.pop_front());
            if (opQueue.size() == 0) mDone = 1'b1;
        end else if (mDone) begin
            if (!execF) mDone = 1'b0;
        end else if (execF) begin
            opQueue.push_back(1'b0);
            repeat (WIDTH) opQueue.push_back(1'b1);
        end
        cycleCount++;
        #1;
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        bit rNow;
        int pressCycle;
        firstSelCycle = -1;
        bus.Execute = 1'b0;
        bus.LoadA   = 1'b0;
        bus.LoadB   = 1'b0;
        Reset       = 1'b1;
        repeat (2) @(posedge Clk);
        opQueue.delete();
        mDone = 1'b0;
        pipe1 = 1'b0;
        pipe2 = 1'b0;
        #1;

        // Reset state and a single-cycle LoadA in IDLE.
        applyStimulus("reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("loada", 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("loada_after", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("load_both", 1'b0, 1'b1, 1'b1, 1'b0);

        // Single press, released immediately; loads ignored while running.
        shiftSeen     = 0;
        firstSelCycle = -1;
        pressCycle    = cycleCount;
        applyStimulus("press", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH + 8; i++)
            applyStimulus("run_short", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        checkCount("compute_latency", firstSelCycle - pressCycle, 1 + EXTRA_LAT);
        checkCount("shifts_short", shiftSeen, WIDTH);

        // Execute held 40 cycles with LoadB high, then released.
        shiftSeen = 0;
        for (int i = 0; i < 40; i++)
            applyStimulus("held", 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            applyStimulus("release", 1'b0, 1'b0, 1'b0, 1'b0);
        checkCount("shifts_held", shiftSeen, WIDTH);

        // Reset asserted during the third shift cycle.
        shiftSeen = 0;
        applyStimulus("press2", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            rNow = (shiftSeen == 2) && (opQueue.size() > 0) && opQueue[0];
            applyStimulus("to_shift3", 1'b0, 1'b0, 1'b0, rNow);
            if (rNow) break;
        end
        for (int i = 0; i < 5; i++)
            applyStimulus("after_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        checkCount("shifts_reset", shiftSeen, 3);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            applyStimulus("random", 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
